// File: rtl/read_burst_ctrl.sv
// read_burst_ctrl: sequences one read burst through latency wait, word receive, timeout flush and completion
module read_burst_ctrl #(
    parameter int BURST_W     = 9,
    parameter int LAT_W       = 8,
    parameter int TIMEOUT_CYC = 255,
    parameter int FLUSH_CYC   = 8
) (
    input  logic               clk0,
    input  logic               rst_i,
    input  logic               start_valid_i,
    output logic               start_ready_o,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic [LAT_W-1:0]   lat_cycles_i,
    output logic               read_clk_en_o,
    output logic               en_ddr_in_o,
    input  logic               fifo_valid_i,
    input  logic [15:0]        fifo_data_i,
    output logic               fifo_ready_o,
    output logic               rx_valid_o,
    output logic [15:0]        rx_data_o,
    output logic               rx_last_o,
    input  logic               rx_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o
);
    localparam int IDLE_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAT, RECV, FLUSH, DONE} state_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] word_q, word_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic               err_q, err_d;

    // state and counter registers; reset aborts any burst in flight
    always_ff @(posedge clk0) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            word_q  <= '0;
            lat_q   <= '0;
            idle_q  <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            lat_q   <= lat_d;
            idle_q  <= idle_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    // next-state, counter updates and outputs; data passes through only while receiving
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        word_d        = word_q;
        lat_d         = lat_q;
        idle_d        = idle_q;
        flush_d       = flush_q;
        err_d         = err_q;
        start_ready_o = 1'b0;
        read_clk_en_o = 1'b0;
        en_ddr_in_o   = 1'b0;
        fifo_ready_o  = 1'b0;
        rx_valid_o    = 1'b0;
        rx_data_o     = '0;
        rx_last_o     = 1'b0;
        done_o        = 1'b0;
        timeout_o     = 1'b0;
        busy_o        = state_q != IDLE;
        case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    len_d   = burst_len_i;
                    lat_d   = lat_cycles_i;
                    word_d  = '0;
                    idle_d  = '0;
                    flush_d = '0;
                    state_d = (burst_len_i == '0) ? DONE : LAT;
                end
            end
            LAT: begin
                if (lat_q == '0) state_d = RECV;
                else lat_d = lat_q - LAT_W'(1);
            end
            RECV: begin
                read_clk_en_o = 1'b1;
                en_ddr_in_o   = 1'b1;
                rx_valid_o    = fifo_valid_i;
                rx_data_o     = fifo_data_i;
                fifo_ready_o  = rx_ready_i;
                rx_last_o     = fifo_valid_i && (word_q == len_q - BURST_W'(1));
                idle_d        = fifo_valid_i ? '0 : idle_q + IDLE_W'(1);
                if (fifo_valid_i && rx_ready_i) begin
                    word_d = word_q + BURST_W'(1);
                    if (rx_last_o) state_d = DONE;
                end else if (!fifo_valid_i && idle_q == IDLE_LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                fifo_ready_o = 1'b1;
                flush_d      = flush_q + FLUSH_W'(1);
                if (flush_q == FLUSH_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                timeout_o = err_q;
                err_d     = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_read_burst_ctrl.sv
// tb_read_burst_ctrl: directed and randomized bursts checked against a transaction-level model
module tb_read_burst_ctrl;
    localparam int BURST_W     = 9;
    localparam int LAT_W       = 8;
    localparam int TIMEOUT_CYC = 255;
    localparam int FLUSH_CYC   = 8;

    logic               clk0 = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_valid_i = 1'b0;
    logic               start_ready_o;
    logic [BURST_W-1:0] burst_len_i = '0;
    logic [LAT_W-1:0]   lat_cycles_i = '0;
    logic               read_clk_en_o;
    logic               en_ddr_in_o;
    logic               fifo_valid_i = 1'b0;
    logic [15:0]        fifo_data_i = '0;
    logic               fifo_ready_o;
    logic               rx_valid_o;
    logic [15:0]        rx_data_o;
    logic               rx_last_o;
    logic               rx_ready_i = 1'b0;
    logic               busy_o;
    logic               done_o;
    logic               timeout_o;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] supply[$];

    read_burst_ctrl #(
        .BURST_W(BURST_W), .LAT_W(LAT_W), .TIMEOUT_CYC(TIMEOUT_CYC), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk0(clk0), .rst_i(rst_i),
        .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
        .burst_len_i(burst_len_i), .lat_cycles_i(lat_cycles_i),
        .read_clk_en_o(read_clk_en_o), .en_ddr_in_o(en_ddr_in_o),
        .fifo_valid_i(fifo_valid_i), .fifo_data_i(fifo_data_i), .fifo_ready_o(fifo_ready_o),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_last_o(rx_last_o), .rx_ready_i(rx_ready_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk0);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic busy);
        chk({tag, " busy"}, busy_o, busy);
        chk({tag, " start_ready"}, start_ready_o, !busy);
        chk({tag, " clk_en"}, read_clk_en_o, 1'b0);
        chk({tag, " en_ddr"}, en_ddr_in_o, 1'b0);
        chk({tag, " rx_valid"}, rx_valid_o, 1'b0);
        chk({tag, " rx_last"}, rx_last_o, 1'b0);
    endtask

    // One burst: len words requested, nsup words offered by the FIFO, rdy_pct/gap_pct shape the
    // handshakes, stall holds rx_ready low for that many valid cycles, rst_after aborts via reset
    // once that many words are delivered, hold keeps start_valid_i high afterwards.
    task automatic burst(input int len, input int lat, input int nsup, input int rdy_pct,
                         input int gap_pct, input int stall, input int rst_after, input bit hold);
        int got, idle, cyc, st;
        supply = {};
        for (int i = 0; i < nsup; i++) supply.push_back(16'($urandom));
        start_valid_i = 1'b1;
        burst_len_i   = BURST_W'(len);
        lat_cycles_i  = LAT_W'(lat);
        fifo_valid_i  = nsup > 0;
        fifo_data_i   = nsup > 0 ? supply[0] : 16'h0;
        rx_ready_i    = 1'b1;
        @(negedge clk0);
        chk("accept start_ready", start_ready_o, 1'b1);
        chk("accept busy", busy_o, 1'b0);
        chk("accept fifo_ready", fifo_ready_o, 1'b0);
        next_cycle();
        start_valid_i = hold;
        burst_len_i   = BURST_W'($urandom);
        lat_cycles_i  = LAT_W'($urandom);
        if (len == 0) begin
            @(negedge clk0);
            chk("zero done", done_o, 1'b1);
            chk("zero timeout", timeout_o, 1'b0);
            check_quiet("zero", 1'b1);
            next_cycle();
            return;
        end
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk0);
            check_quiet("lat", 1'b1);
            chk("lat fifo_ready", fifo_ready_o, 1'b0);
            chk("lat done", done_o, 1'b0);
            next_cycle();
        end
        got = 0; idle = 0; cyc = 0; st = stall;
        while (got < len && idle < TIMEOUT_CYC && cyc < 5000 && !(rst_after >= 0 && got == rst_after)) begin
            fifo_valid_i = supply.size() > 0 && ($urandom_range(99) >= gap_pct);
            fifo_data_i  = fifo_valid_i ? supply[0] : 16'($urandom);
            rx_ready_i   = st > 0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (st > 0 && fifo_valid_i) st--;
            @(negedge clk0);
            chk("recv clk_en", read_clk_en_o, 1'b1);
            chk("recv en_ddr", en_ddr_in_o, 1'b1);
            chk("recv start_ready", start_ready_o, 1'b0);
            chk("recv rx_valid", rx_valid_o, fifo_valid_i);
            chk("recv fifo_ready", fifo_ready_o, rx_ready_i);
            chk("recv rx_last", rx_last_o, fifo_valid_i && got == len - 1);
            if (fifo_valid_i) chk("recv rx_data", rx_data_o, supply[0]);
            if (fifo_valid_i && rx_ready_i) begin
                void'(supply.pop_front());
                got++;
            end
            idle = fifo_valid_i ? 0 : idle + 1;
            cyc++;
            next_cycle();
        end
        fifo_valid_i = supply.size() > 0;
        fifo_data_i  = 16'($urandom);
        if (rst_after >= 0 && got == rst_after) begin
            rst_i = 1'b1;
            next_cycle();
            rst_i = 1'b0;
            start_valid_i = 1'b0;
            @(negedge clk0);
            check_quiet("post-reset", 1'b0);
            chk("post-reset fifo_ready", fifo_ready_o, 1'b0);
            chk("post-reset done", done_o, 1'b0);
            next_cycle();
            return;
        end
        if (idle >= TIMEOUT_CYC) begin
            fifo_valid_i = 1'b1;
            for (int i = 0; i < FLUSH_CYC; i++) begin
                @(negedge clk0);
                check_quiet("flush", 1'b1);
                chk("flush fifo_ready", fifo_ready_o, 1'b1);
                chk("flush done", done_o, 1'b0);
                next_cycle();
            end
        end else begin
            chk("recv words within budget", got, len);
        end
        @(negedge clk0);
        chk("done pulse", done_o, 1'b1);
        chk("done timeout", timeout_o, idle >= TIMEOUT_CYC);
        chk("done fifo_ready", fifo_ready_o, 1'b0);
        check_quiet("done", 1'b1);
        next_cycle();
        if (!hold) begin
            start_valid_i = 1'b0;
            @(negedge clk0);
            check_quiet("idle after", 1'b0);
            chk("idle done", done_o, 1'b0);
            chk("idle timeout", timeout_o, 1'b0);
            next_cycle();
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_valid_i = 1'b1;
        burst_len_i = BURST_W'(5);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        start_valid_i = 1'b0;
        @(negedge clk0);
        check_quiet("reset", 1'b0);
        chk("reset fifo_ready", fifo_ready_o, 1'b0);
        chk("reset done", done_o, 1'b0);
        chk("reset timeout", timeout_o, 1'b0);
        next_cycle();
        burst(4, 3, 4, 100, 0, 0, -1, 1'b0);
        burst(0, 0, 0, 100, 0, 0, -1, 1'b0);
        burst(3, $urandom_range(5), 3, 50, 0, 300, -1, 1'b0);
        burst(8, $urandom_range(5), 2, 100, 0, 0, -1, 1'b0);
        burst(6, 2, 6, 100, 0, 0, 2, 1'b0);
        burst(1, $urandom_range(5), 1, 100, 0, 0, -1, 1'b0);
        burst(5, $urandom_range(4), 7, 80, 20, 0, -1, 1'b1);
        burst(3, $urandom_range(4), 3, 80, 20, 0, -1, 1'b1);
        burst(2, 0, 4, 100, 0, 0, -1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            int len;
            len = $urandom_range(1, 16);
            burst(len, $urandom_range(10), len + $urandom_range(3), 70, 30, 0, -1, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
